// File: rtl/apb_mux_pkg.sv
// Shared types and constants for the APB completer multiplexer with
// access-phase watchdog.
package apb_mux_pkg;

    // Widest PRDATA the zero constant covers.
    localparam int MAX_DATA_W = 1024;
    localparam logic [MAX_DATA_W-1:0] ZERO_DATA = '0;

    // Smallest legal watchdog counter width.
    localparam int WDT_MIN_W = 1;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_SETUP  = 2'd1;
    localparam state_t ST_ACCESS = 2'd2;
    localparam state_t ST_ABORT  = 2'd3;

    // Width needed to hold 0..timeout; never narrower than one bit.
    function automatic int wdt_cnt_w(input int timeout);
        if (timeout < 1) begin
            return WDT_MIN_W;
        end
        return (timeout + 1 > 2) ? $clog2(timeout + 1) : WDT_MIN_W;
    endfunction

endpackage

// File: rtl/apb_mux_watchdog.sv
// Access-phase watchdog: counts consecutive not-ready access cycles and
// pulses expire_o in the last allowed cycle. TIMEOUT=0 removes the counter.
module apb_mux_watchdog
    import apb_mux_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic in_access_i,
    input  logic ready_i,
    output logic expire_o
);

    generate
        if (TIMEOUT == 0) begin : g_bypass
            logic unused_wdt;
            assign unused_wdt = ^{clk_i, rst_i, in_access_i, ready_i};
            assign expire_o   = 1'b0;
        end else begin : g_count
            localparam int CW = wdt_cnt_w(TIMEOUT);
            localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
            localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

            logic [CW-1:0] cnt_q, cnt_d;

            // Count stalled access cycles, cleared outside ACCESS, saturating.
            always_comb begin
                cnt_d = cnt_q;
                if (!in_access_i) begin
                    cnt_d = '0;
                end else if (!ready_i && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            // Counter register.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            // This stalled cycle brings the count to TIMEOUT: abort next cycle.
            assign expire_o = in_access_i & ~ready_i & (cnt_q == CNT_LAST);
        end
    endgenerate

endmodule

// File: rtl/apb_slave_mux_wdt.sv
// APB completer multiplexer with per-transfer access-phase watchdog, sticky
// per-port hung quarantine and error response for unreachable decodes.
// Optional build macro: APB_MUX_ERRCNT_EN adds a saturating error-transfer
// counter (ERR_CNT) with a synchronous clear (ERR_CNT_CLR).
//
// state  | meaning
// IDLE   | no transfer in flight; PSEL high here is the setup phase
// SETUP  | setup phase of a back-to-back transfer
// ACCESS | access phase, waiting for the completer (watchdog running)
// ABORT  | one-cycle error completion after watchdog expiry
module apb_slave_mux_wdt
    import apb_mux_pkg::*;
#(
    parameter int                   DEC_W     = 4,
    parameter int                   NUM_PORTS = 4,
    parameter logic [NUM_PORTS-1:0] PORT_EN   = '1,
    parameter int                   DATA_W    = 32,
    parameter int                   TIMEOUT   = 64
) (
    input  logic                          PCLK,
    input  logic                          PRESET,
    input  logic [DEC_W-1:0]              DECODE,
    input  logic                          PSEL,
    input  logic                          PENABLE,
    output logic [NUM_PORTS-1:0]          PSELS,
    input  logic [NUM_PORTS-1:0]          PREADYS,
    input  logic [NUM_PORTS*DATA_W-1:0]   PRDATAS,
    input  logic [NUM_PORTS-1:0]          PSLVERRS,
    output logic                          PREADY,
    output logic [DATA_W-1:0]             PRDATA,
    output logic                          PSLVERR,
    output logic [NUM_PORTS-1:0]          HUNG,
    input  logic [NUM_PORTS-1:0]          HUNG_CLR,
    output logic                          TIMEOUT_IRQ
`ifdef APB_MUX_ERRCNT_EN
    ,
    output logic [15:0]                   ERR_CNT,
    input  logic                          ERR_CNT_CLR
`endif
);

    localparam logic [DATA_W-1:0] ZERO_D = ZERO_DATA[DATA_W-1:0];

    state_t               state_q, state_d;
    logic [NUM_PORTS-1:0] hung_q, hung_d;
    logic [NUM_PORTS-1:0] hit, set_vec;
    logic [DEC_W-1:0]     abort_port_q, abort_port_d;
    logic                 rdy_sel, err_sel;
    logic [DATA_W-1:0]    data_sel;
    logic                 dec_valid, in_access, in_abort, expire;

    // The FSM follows PSEL alone; PENABLE in IDLE is therefore handled as setup.
    logic unused_penable;
    assign unused_penable = PENABLE;

    assign in_access = (state_q == ST_ACCESS);
    assign in_abort  = (state_q == ST_ABORT);

    // Decode to a reachable port and pick its completer signals.
    always_comb begin
        hit      = '0;
        rdy_sel  = 1'b0;
        err_sel  = 1'b0;
        data_sel = ZERO_D;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (PSEL && (DECODE == DEC_W'(i)) && PORT_EN[i] && !hung_q[i]) begin
                hit[i]   = 1'b1;
                rdy_sel  = PREADYS[i];
                err_sel  = PSLVERRS[i];
                data_sel = PRDATAS[i*DATA_W +: DATA_W];
            end
        end
    end

    assign dec_valid = |hit;
    assign PSELS     = in_abort ? '0 : hit;

    // Requester-side response: abort, idle, normal mux or decode error.
    always_comb begin
        PREADY  = 1'b1;
        PSLVERR = 1'b0;
        PRDATA  = ZERO_D;
        if (in_abort) begin
            PSLVERR = 1'b1;
        end else if (PSEL) begin
            if (dec_valid) begin
                PREADY  = rdy_sel;
                PSLVERR = err_sel;
                PRDATA  = data_sel;
            end else begin
                PSLVERR = in_access;
            end
        end
    end

    apb_mux_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdt (
        .clk_i       (PCLK),
        .rst_i       (PRESET),
        .in_access_i (in_access),
        .ready_i     (PREADY),
        .expire_o    (expire)
    );

    // Transfer sequencing; the aborted port index is captured at expiry.
    always_comb begin
        state_d      = state_q;
        abort_port_d = abort_port_q;
        case (state_q)
            ST_IDLE: begin
                if (PSEL) begin
                    state_d = ST_ACCESS;
                end
            end
            ST_SETUP: begin
                state_d = PSEL ? ST_ACCESS : ST_IDLE;
            end
            ST_ACCESS: begin
                if (expire) begin
                    state_d      = ST_ABORT;
                    abort_port_d = DECODE;
                end else if (PREADY) begin
                    state_d = PSEL ? ST_SETUP : ST_IDLE;
                end
            end
            ST_ABORT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Quarantine set at the end of ABORT; a same-cycle clear loses to the set.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            set_vec[i] = in_abort && (abort_port_q == DEC_W'(i));
        end
        hung_d = (hung_q & ~HUNG_CLR) | set_vec;
    end

    // State, abort index and hung flags.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q      <= ST_IDLE;
            abort_port_q <= '0;
            hung_q       <= '0;
        end else begin
            state_q      <= state_d;
            abort_port_q <= abort_port_d;
            hung_q       <= hung_d;
        end
    end

    assign HUNG        = hung_q;
    assign TIMEOUT_IRQ = |hung_q;

`ifdef APB_MUX_ERRCNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;
    logic        err_evt;

    // A transfer completes in ACCESS with PREADY, or in ABORT.
    assign err_evt = (in_access | in_abort) & PREADY & PSLVERR;

    // Saturating error-transfer count; clear has priority over increment.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (ERR_CNT_CLR) begin
            err_cnt_d = '0;
        end else if (err_evt && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    // Error counter register.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign ERR_CNT = err_cnt_q;
`endif

endmodule

// File: tb/tb_apb_slave_mux_wdt.sv
// Bench for apb_slave_mux_wdt: scoreboard of expected completions, a small
// reference model of the quarantine flags and error count.
module tb_apb_slave_mux_wdt;

    localparam int              DEC_W = 4;
    localparam int              NP    = 4;
    localparam int              DW    = 32;
    localparam int              TO    = 8;
    localparam logic [NP-1:0]   PEN   = 4'b0111;

    logic                 PCLK;
    logic                 PRESET;
    logic [DEC_W-1:0]     DECODE;
    logic                 PSEL;
    logic                 PENABLE;
    logic [NP-1:0]        PSELS;
    logic [NP-1:0]        PREADYS;
    logic [NP*DW-1:0]     PRDATAS;
    logic [NP-1:0]        PSLVERRS;
    logic                 PREADY;
    logic [DW-1:0]        PRDATA;
    logic                 PSLVERR;
    logic [NP-1:0]        HUNG;
    logic [NP-1:0]        HUNG_CLR;
    logic                 TIMEOUT_IRQ;
`ifdef APB_MUX_ERRCNT_EN
    logic [15:0]          ERR_CNT;
    logic                 ERR_CNT_CLR;
`endif

    apb_slave_mux_wdt #(
        .DEC_W     (DEC_W),
        .NUM_PORTS (NP),
        .PORT_EN   (PEN),
        .DATA_W    (DW),
        .TIMEOUT   (TO)
    ) dut (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .DECODE      (DECODE),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PSELS       (PSELS),
        .PREADYS     (PREADYS),
        .PRDATAS     (PRDATAS),
        .PSLVERRS    (PSLVERRS),
        .PREADY      (PREADY),
        .PRDATA      (PRDATA),
        .PSLVERR     (PSLVERR),
        .HUNG        (HUNG),
        .HUNG_CLR    (HUNG_CLR),
        .TIMEOUT_IRQ (TIMEOUT_IRQ)
`ifdef APB_MUX_ERRCNT_EN
        ,
        .ERR_CNT     (ERR_CNT),
        .ERR_CNT_CLR (ERR_CNT_CLR)
`endif
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          err;
        logic [NP-1:0] psels;
        logic [7:0]    cycles;
    } exp_t;

    exp_t          sb_q[$];
    int            n_cmp;
    int            n_err;
    logic [NP-1:0] hung_m;
    int            err_m;

    function automatic logic [DW-1:0] pdata(input int p);
        logic [DW-1:0] base;
        base = 32'hA5A5_0000;
        return base | DW'(p);
    endfunction

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One transfer; waits<0 means the completer never answers.
    task automatic xfer(input int port, input int waits, input logic serr, input logic clr_at_abort);
        exp_t          e;
        exp_t          got;
        logic          valid;
        logic          abort;
        logic          done;
        logic [NP-1:0] oh;
        valid = 1'b0;
        if (port < NP) valid = PEN[port] && !hung_m[port];
        oh    = (port < NP) ? (NP'(1) << port) : '0;
        abort = valid && ((waits < 0) || (waits >= TO));
        if (!valid) begin
            e.data = '0; e.err = 1'b1; e.psels = '0; e.cycles = 8'd1;
        end else if (abort) begin
            e.data = '0; e.err = 1'b1; e.psels = '0; e.cycles = 8'(TO + 1);
        end else begin
            e.data = pdata(port); e.err = serr; e.psels = oh; e.cycles = 8'(waits + 1);
        end
        sb_q.push_back(e);

        @(negedge PCLK);
        PSEL     = 1'b1;
        PENABLE  = 1'b0;
        DECODE   = DEC_W'(port);
        PSLVERRS = serr ? oh : '0;
        PREADYS  = '1;
        if ((port < NP) && (waits != 0)) PREADYS[port] = 1'b0;
        #1;
        chk("setup_psels", PSELS, valid ? oh : '0);
        if (!valid) begin
            chk("setup_pready", PREADY, 1'b1);
            chk("setup_pslverr", PSLVERR, 1'b0);
        end

        done = 1'b0;
        for (int k = 0; k < TO + 4; k++) begin
            @(negedge PCLK);
            PENABLE = 1'b1;
            if (port < NP) PREADYS[port] = (waits >= 0) && (k >= waits);
            HUNG_CLR = (clr_at_abort && (k == TO)) ? oh : '0;
            #1;
            if (PREADY) begin
                done = 1'b1;
                got  = sb_q.pop_front();
                chk("prdata", PRDATA, got.data);
                chk("pslverr", PSLVERR, got.err);
                chk("psels_done", PSELS, got.psels);
                chk("acc_cycles", k + 1, got.cycles);
                break;
            end
        end
        if (!done) begin
            chk("xfer_timeout", 1'b0, 1'b1);
            got = sb_q.pop_front();
        end
        if (abort) hung_m[port] = 1'b1;
        if (e.err) err_m++;

        @(negedge PCLK);
        PSEL     = 1'b0;
        PENABLE  = 1'b0;
        PREADYS  = '1;
        PSLVERRS = '0;
        HUNG_CLR = '0;
        #1;
        chk("hung", HUNG, hung_m);
        chk("irq", TIMEOUT_IRQ, |hung_m);
        chk("idle_pready", PREADY, 1'b1);
    endtask

    task automatic clr_hung(input logic [NP-1:0] mask);
        @(negedge PCLK);
        HUNG_CLR = mask;
        @(negedge PCLK);
        HUNG_CLR = '0;
        hung_m   = hung_m & ~mask;
        #1;
        chk("hung_clr", HUNG, hung_m);
        chk("irq_clr", TIMEOUT_IRQ, |hung_m);
    endtask

    task automatic idle_checks(input string tag);
        chk({tag, "_pready"}, PREADY, 1'b1);
        chk({tag, "_pslverr"}, PSLVERR, 1'b0);
        chk({tag, "_prdata"}, PRDATA, '0);
        chk({tag, "_psels"}, PSELS, '0);
        chk({tag, "_hung"}, HUNG, '0);
        chk({tag, "_irq"}, TIMEOUT_IRQ, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish, required finish before 200000");
        $fatal(1);
    end

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        hung_m   = '0;
        err_m    = 0;
        PRESET   = 1'b1;
        PSEL     = 1'b0;
        PENABLE  = 1'b0;
        DECODE   = '0;
        PREADYS  = '1;
        PSLVERRS = '0;
        HUNG_CLR = '0;
`ifdef APB_MUX_ERRCNT_EN
        ERR_CNT_CLR = 1'b0;
`endif
        for (int p = 0; p < NP; p++) PRDATAS[p*DW +: DW] = pdata(p);

        repeat (3) @(negedge PCLK);
        PRESET = 1'b0;
        #1;
        idle_checks("reset");
`ifdef APB_MUX_ERRCNT_EN
        chk("reset_err_cnt", ERR_CNT, 16'd0);
`endif

        xfer(2, 3, 1'b0, 1'b0);       // three wait states, normal read
        xfer(0, 0, 1'b1, 1'b0);       // completer error, zero waits
        xfer(5, 0, 1'b0, 1'b0);       // out-of-range decode
        xfer(3, 0, 1'b0, 1'b0);       // disabled port
        xfer(1, -1, 1'b0, 1'b0);      // hung completer -> abort on cycle TO+1
        xfer(1, 0, 1'b0, 1'b0);       // quarantined port -> immediate error
        clr_hung(4'b0010);
        xfer(1, TO, 1'b0, 1'b1);      // late ready ignored; clear during abort loses
        clr_hung(4'b0010);
        xfer(1, TO - 1, 1'b0, 1'b0);  // ready on the last allowed cycle completes

        // Reset in the middle of a stalled access phase.
        @(negedge PCLK);
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        DECODE  = DEC_W'(2);
        PREADYS = 4'b1011;
        for (int k = 0; k < 6; k++) begin
            @(negedge PCLK);
            PENABLE = 1'b1;
            #1;
            chk("mid_wait_pready", PREADY, 1'b0);
        end
        PRESET = 1'b1;
        @(negedge PCLK);
        PRESET  = 1'b0;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PREADYS = '1;
        hung_m  = '0;
        err_m   = 0;
        #1;
        idle_checks("mid_reset");
        xfer(2, TO - 1, 1'b0, 1'b0);  // full wait budget available after reset

`ifdef APB_MUX_ERRCNT_EN
        xfer(5, 0, 1'b0, 1'b0);
        xfer(3, 0, 1'b0, 1'b0);
        xfer(0, 0, 1'b1, 1'b0);
        chk("err_cnt", ERR_CNT, 16'(err_m));
        chk("err_cnt_three", ERR_CNT, 16'd3);
        @(negedge PCLK);
        ERR_CNT_CLR = 1'b1;
        @(negedge PCLK);
        ERR_CNT_CLR = 1'b0;
        err_m       = 0;
        #1;
        chk("err_cnt_clr", ERR_CNT, 16'd0);
`endif

        chk("sb_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
